game_status_tracker: RTL and testbench
======================================

Name: game_status_tracker

Overview:
- Battleship turn/score engine. It sits directly upstream of the seven-segment display driver and produces `turns_left[4:0]`, `win` and `lose` for it.
- It accepts debounced fire requests and issues a board lookup request for each one.
- It consumes the hit/miss result, then updates remaining turns and hit count and declares win or lose.
- Single clock domain, shared with the VGA/board logic.

Parameters:
- MAX_TURNS, 20, turns granted per game; legal range 1..31 (fits 5 bits).
- SHIP_CELLS, 17, total occupied ship cells; hits needed to win; legal range 1..63.
- RESULT_TIMEOUT, 15, cycles to wait for `res_valid` before abandoning the shot; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a new game from any state
- fire  in  1  single-cycle pulse; player fires at the current cursor cell
- lookup_req  out  1  single-cycle pulse; board must answer with `res_valid`
- res_valid  in  1  single-cycle pulse; lookup result present
- res_hit  in  1  cell holds a ship (qualified by `res_valid`)
- res_repeat  in  1  cell already fired on (qualified by `res_valid`)
- busy  out  1  high while a shot is outstanding
- turns_left  out  5  remaining turns, binary
- hits  out  6  ship cells hit so far
- win  out  1  game won, sticky until `start` or reset
- lose  out  1  game lost, sticky until `start` or reset
- timeout_err  out  1  one-cycle pulse when a lookup times out

Behaviour:
- Reset (asynchronous, `rst_n` low) puts every output in its reset value:
  - state = IDLE, `turns_left` = 0, `hits` = 0
  - `win` = `lose` = `busy` = `lookup_req` = `timeout_err` = 0
- States: IDLE, READY, WAIT_RES, OVER.
- IDLE: only `start` is honoured. On `start`: `turns_left` <= MAX_TURNS, `hits` <= 0, go to READY.
- READY, on `fire`:
  - `lookup_req` pulses high the next cycle.
  - `busy` is set in that same cycle.
  - Timeout counter clears; go to WAIT_RES.
- WAIT_RES: `busy` = 1 and the timeout counter increments each cycle. On `res_valid`:
  - `res_repeat` = 1: no change to `hits` or `turns_left` (a repeat shot consumes nothing; see Optional Feature).
  - else `res_hit` = 1: `hits` increments (saturating at 63). `turns_left` decrements.
  - else: `turns_left` decrements.
  - Then evaluate, with win taking priority:
    - `hits` (new value) == SHIP_CELLS: `win` <= 1, go to OVER.
    - else `turns_left` (new value) == 0: `lose` <= 1, go to OVER.
    - else go to READY, `busy` <= 0.
  - Win beats lose when the last turn sinks the final ship.
- Timeout: if the counter reaches RESULT_TIMEOUT with no `res_valid`:
  - `timeout_err` pulses for one cycle.
  - Return to READY; no counts change.
- OVER: `win`/`lose` held; `fire` and `res_valid` are ignored.
- `start` in any state restarts the game the next cycle:
  - counters reload, `win` = `lose` = `busy` = 0.
  - An in-flight lookup is abandoned; a late `res_valid` in READY is ignored.
- `fire` while `busy` or in IDLE/OVER is dropped, not queued.
- `start` and `fire` in the same cycle: `start` wins and `fire` is dropped.
- Other rules:
  - `res_valid` outside WAIT_RES is ignored.
  - `turns_left` never underflows below 0.
  - `win` and `lose` are never both 1.
  - All outputs are registered; the display sees an update one cycle after `res_valid`.

Optional Feature:
- Macro `REPEAT_COSTS_TURN_EN`.
- Defined: a `res_repeat` result decrements `turns_left` like a miss, and the lose check applies.
- Undefined: repeat shots are free, as described above.

Decomposition:
- Shared package `battleship_pkg` holds:
  - the state enum (IDLE, READY, WAIT_RES, OVER)
  - widths TURN_W = 5 and HIT_W = 6
  - default constants MAX_TURNS_DEF = 20 and SHIP_CELLS_DEF = 17
- One natural sub-module: `shot_timeout_counter`, a load/clear/terminal-count counter used for the WAIT_RES timeout.
- Remaining logic stays in a single FSM.

Test Plan:
- Reset then `start` -> `turns_left` = 20, `hits` = 0, `win` = `lose` = 0, `busy` = 0.
- `fire`, `res_valid` with `res_hit` = 1 two cycles later -> `lookup_req` pulses once, `hits` = 1, `turns_left` = 19, `busy` drops.
- 20 misses -> after the 20th, `turns_left` = 0, `lose` = 1; a further `fire` produces no `lookup_req`.
- With SHIP_CELLS = 3, MAX_TURNS = 3: three hits -> `win` = 1, `lose` = 0, `turns_left` = 0 (win priority).
- `fire`, no response for 15 cycles -> `timeout_err` pulses, counts unchanged; a late `res_valid` is ignored.
- `res_repeat` result -> `turns_left` unchanged without the macro, decremented by 1 with `REPEAT_COSTS_TURN_EN`.
- Assert `rst_n` low mid-WAIT_RES -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship turn/score engine.
// Contents: FSM state enum, counter widths, default game constants and
// a saturating hit-counter increment helper.
package battleship_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READY    = 2'd1,
        WAIT_RES = 2'd2,
        OVER     = 2'd3
    } state_t;

    localparam int TURN_W             = 5;
    localparam int HIT_W              = 6;
    localparam int TMO_W              = 8;
    localparam int MAX_TURNS_DEF      = 20;
    localparam int SHIP_CELLS_DEF     = 17;
    localparam int RESULT_TIMEOUT_DEF = 15;

    function automatic logic [HIT_W-1:0] hits_sat_inc(input logic [HIT_W-1:0] h);
        return (h == {HIT_W{1'b1}}) ? h : h + 1'b1;
    endfunction

endpackage

// File: rtl/shot_timeout_counter.sv
// Down-counter with load and terminal-count flag, used to bound the wait
// for a board lookup result.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   load        load load_val (takes priority over dec)
//   load_val    start value; tc asserts load_val+1 decrement cycles later
//   dec         count down by one, holding at zero
//   tc          count is zero
module shot_timeout_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/game_status_tracker.sv
// Battleship turn/score engine feeding the seven-segment display driver.
// Accepts fire pulses, issues a board lookup per shot, consumes the
// hit/miss/repeat result and tracks remaining turns, hits, win and lose.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   start                 begin a new game from any state
//   fire                  shoot at the cursor cell (dropped unless READY)
//   lookup_req            one-cycle board lookup request
//   res_valid/hit/repeat  board lookup result
//   busy                  shot outstanding
//   turns_left, hits      game counters
//   win, lose             sticky game outcome
//   timeout_err           one-cycle pulse when a lookup goes unanswered
// Build option: define REPEAT_COSTS_TURN_EN to charge a turn for repeat shots.
//
// state    | meaning
// IDLE     | after reset, waiting for start
// READY    | game running, waiting for fire
// WAIT_RES | lookup issued, waiting for result or timeout
// OVER     | game won or lost, waiting for start
module game_status_tracker
    import battleship_pkg::*;
#(
    parameter int MAX_TURNS      = MAX_TURNS_DEF,
    parameter int SHIP_CELLS     = SHIP_CELLS_DEF,
    parameter int RESULT_TIMEOUT = RESULT_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              fire,
    output logic              lookup_req,
    input  logic              res_valid,
    input  logic              res_hit,
    input  logic              res_repeat,
    output logic              busy,
    output logic [TURN_W-1:0] turns_left,
    output logic [HIT_W-1:0]  hits,
    output logic              win,
    output logic              lose,
    output logic              timeout_err
);

`ifdef REPEAT_COSTS_TURN_EN
    localparam bit REPEAT_COSTS = 1'b1;
`else
    localparam bit REPEAT_COSTS = 1'b0;
`endif

    state_t            state, state_nxt;
    logic [TURN_W-1:0] turns_upd, turns_d;
    logic [HIT_W-1:0]  hits_upd, hits_d;
    logic              win_hit, lose_hit;
    logic              win_d, lose_d, busy_d, lookup_d, tmo_err_d;
    logic              tmo_load, tmo_tc;

    // Counter is armed on the accepted fire so it covers exactly the
    // RESULT_TIMEOUT cycles spent in WAIT_RES.
    assign tmo_load = (state == READY) && fire && !start;

    shot_timeout_counter #(.W(TMO_W)) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmo_load),
        .load_val(TMO_W'(RESULT_TIMEOUT - 1)),
        .dec     (state == WAIT_RES),
        .tc      (tmo_tc)
    );

    // Counter values a result would produce this cycle.
    always_comb begin
        hits_upd  = hits;
        turns_upd = turns_left;
        if (!res_repeat && res_hit) begin
            hits_upd = hits_sat_inc(hits);
        end
        if ((!res_repeat || REPEAT_COSTS) && (turns_left != '0)) begin
            turns_upd = turns_left - 1'b1;
        end
        win_hit  = (hits_upd == HIT_W'(SHIP_CELLS));
        lose_hit = (turns_upd == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            turns_left  <= '0;
            hits        <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
            busy        <= 1'b0;
            lookup_req  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            turns_left  <= turns_d;
            hits        <= hits_d;
            win         <= win_d;
            lose        <= lose_d;
            busy        <= busy_d;
            lookup_req  <= lookup_d;
            timeout_err <= tmo_err_d;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = READY;
        end else begin
            case (state)
                READY: begin
                    if (fire) state_nxt = WAIT_RES;
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        state_nxt = (win_hit || lose_hit) ? OVER : READY;
                    end else if (tmo_tc) begin
                        state_nxt = READY;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        turns_d   = turns_left;
        hits_d    = hits;
        win_d     = win;
        lose_d    = lose;
        busy_d    = busy;
        lookup_d  = 1'b0;
        tmo_err_d = 1'b0;
        if (start) begin
            turns_d = TURN_W'(MAX_TURNS);
            hits_d  = '0;
            win_d   = 1'b0;
            lose_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state)
                READY: begin
                    if (fire) begin
                        lookup_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        turns_d = turns_upd;
                        hits_d  = hits_upd;
                        busy_d  = 1'b0;
                        if (win_hit)       win_d  = 1'b1;
                        else if (lose_hit) lose_d = 1'b1;
                    end else if (tmo_tc) begin
                        tmo_err_d = 1'b1;
                        busy_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_status_tracker.sv
`timescale 1ns/1ps
module tb_game_status_tracker;

`ifdef REPEAT_COSTS_TURN_EN
    localparam bit REP_COST = 1'b1;
`else
    localparam bit REP_COST = 1'b0;
`endif

    localparam int K_LOOKUP  = 0;
    localparam int K_RESULT  = 1;
    localparam int K_TIMEOUT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 0, fire = 0, res_valid = 0, res_hit = 0, res_repeat = 0;
    logic lookup_req, busy, win, lose, timeout_err;
    logic [4:0] turns_left;
    logic [5:0] hits;

    logic s_start = 0, s_fire = 0, s_rv = 0, s_hit = 0, s_rep = 0;
    logic s_lookup, s_busy, s_win, s_lose, s_tmo;
    logic [4:0] s_turns;
    logic [5:0] s_hits;

    always #5 clk = ~clk;

    game_status_tracker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fire(fire),
        .lookup_req(lookup_req), .res_valid(res_valid), .res_hit(res_hit),
        .res_repeat(res_repeat), .busy(busy), .turns_left(turns_left),
        .hits(hits), .win(win), .lose(lose), .timeout_err(timeout_err)
    );

    game_status_tracker #(.MAX_TURNS(3), .SHIP_CELLS(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .fire(s_fire),
        .lookup_req(s_lookup), .res_valid(s_rv), .res_hit(s_hit),
        .res_repeat(s_rep), .busy(s_busy), .turns_left(s_turns),
        .hits(s_hits), .win(s_win), .lose(s_lose), .timeout_err(s_tmo)
    );

    typedef struct {
        int kind;
        int turns;
        int hits;
        int win;
        int lose;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int m_turns = 0, m_hits = 0, m_win = 0, m_lose = 0;
    logic busy_prev = 1'b0;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int k);
        exp_t e;
        e.kind  = k;
        e.turns = m_turns;
        e.hits  = m_hits;
        e.win   = m_win;
        e.lose  = m_lose;
        sb.push_back(e);
    endtask

    task automatic model_start();
        m_turns = 20; m_hits = 0; m_win = 0; m_lose = 0;
    endtask

    task automatic do_start();
        start = 1; step(); start = 0;
        model_start();
    endtask

    task automatic do_fire();
        push(K_LOOKUP);
        fire = 1; step(); fire = 0;
    endtask

    task automatic shot(input bit h, input bit r, input int gap);
        do_fire();
        repeat (gap) step();
        if (r) begin
            if (REP_COST && m_turns > 0) m_turns--;
        end else begin
            if (h && m_hits < 63) m_hits++;
            if (m_turns > 0) m_turns--;
        end
        if (m_hits == 17) m_win = 1;
        else if (m_turns == 0) m_lose = 1;
        push(K_RESULT);
        res_valid = 1; res_hit = h; res_repeat = r;
        step();
        res_valid = 0; res_hit = 0; res_repeat = 0;
        step();
    endtask

    task automatic ev(int k);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event_kind", k, -1);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", k, e.kind);
            chk("ev_turns", int'(turns_left), e.turns);
            chk("ev_hits", int'(hits), e.hits);
            chk("ev_win", int'(win), e.win);
            chk("ev_lose", int'(lose), e.lose);
            chk("ev_busy", int'(busy), (k == K_LOOKUP) ? 1 : 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
        end else begin
            if (lookup_req) ev(K_LOOKUP);
            if (timeout_err) ev(K_TIMEOUT);
            else if (busy_prev && !busy) ev(K_RESULT);
            busy_prev = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(string tag);
        chk({tag, "_turns"}, int'(turns_left), 0);
        chk({tag, "_hits"}, int'(hits), 0);
        chk({tag, "_win"}, int'(win), 0);
        chk({tag, "_lose"}, int'(lose), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_lookup"}, int'(lookup_req), 0);
        chk({tag, "_tmo"}, int'(timeout_err), 0);
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        rst_n = 1;
        step();

        do_start();
        chk("start_turns", int'(turns_left), 20);
        chk("start_hits", int'(hits), 0);
        chk("start_busy", int'(busy), 0);
        chk("start_winlose", int'({win, lose}), 0);

        // hit answered one cycle after lookup_req
        shot(1'b1, 1'b0, 1);
        chk("hit_turns", int'(turns_left), 19);
        chk("hit_hits", int'(hits), 1);
        chk("hit_busy", int'(busy), 0);

        // repeat shot
        shot(1'b0, 1'b1, 0);
        chk("repeat_turns", int'(turns_left), REP_COST ? 18 : 19);

        // miss answered in the last cycle before timeout
        shot(1'b0, 1'b0, 14);
        chk("late_ok_turns", int'(turns_left), REP_COST ? 17 : 18);

        // timeout: no result for 15 cycles
        do_fire();
        repeat (14) step();
        chk("tmo_busy_before", int'(busy), 1);
        chk("tmo_err_before", int'(timeout_err), 0);
        push(K_TIMEOUT);
        step();
        chk("tmo_err_pulse", int'(timeout_err), 1);
        chk("tmo_busy_after", int'(busy), 0);
        res_valid = 1; res_hit = 1;
        step();
        res_valid = 0; res_hit = 0;
        chk("tmo_err_one_cycle", int'(timeout_err), 0);
        step();
        chk("tmo_late_turns", int'(turns_left), m_turns);
        chk("tmo_late_hits", int'(hits), m_hits);

        // start and fire together: start wins, no lookup
        start = 1; fire = 1; step(); start = 0; fire = 0;
        model_start();
        step();
        chk("startfire_turns", int'(turns_left), 20);
        chk("startfire_lookup", int'(lookup_req), 0);

        // start abandons an in-flight lookup; late result ignored
        shot(1'b1, 1'b0, 0);
        do_fire();
        step();
        model_start();
        push(K_RESULT);
        start = 1; step(); start = 0;
        res_valid = 1; res_hit = 1; step(); res_valid = 0; res_hit = 0;
        step();
        chk("abandon_turns", int'(turns_left), 20);
        chk("abandon_hits", int'(hits), 0);

        // twenty misses lose the game
        for (int i = 0; i < 20; i++) shot(1'b0, 1'b0, 0);
        chk("lose_turns", int'(turns_left), 0);
        chk("lose_flag", int'(lose), 1);
        chk("lose_nowin", int'(win), 0);
        fire = 1; step(); fire = 0;
        chk("over_no_lookup", int'(lookup_req), 0);
        res_valid = 1; res_hit = 1; step(); res_valid = 0; res_hit = 0;
        step();
        chk("over_hits", int'(hits), 0);
        chk("over_lose_held", int'(lose), 1);

        // asynchronous reset in WAIT_RES
        do_start();
        do_fire();
        step();
        #3 rst_n = 0;
        #2;
        chk_all_zero("async_rst");
        step();
        rst_n = 1;
        model_start();
        step();

        // small config: last turn sinks the final ship
        s_start = 1; step(); s_start = 0;
        chk("small_start_turns", int'(s_turns), 3);
        for (int i = 0; i < 3; i++) begin
            s_fire = 1; step(); s_fire = 0;
            step();
            s_rv = 1; s_hit = 1; step(); s_rv = 0; s_hit = 0;
            step();
            if (i == 1) begin
                chk("small_mid_turns", int'(s_turns), 1);
                chk("small_mid_win", int'(s_win), 0);
            end
        end
        chk("small_win", int'(s_win), 1);
        chk("small_lose", int'(s_lose), 0);
        chk("small_turns", int'(s_turns), 0);
        chk("small_hits", int'(s_hits), 3);
        chk("small_busy", int'(s_busy), 0);

        step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
